mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

- Shares the single backing-memory port between instruction-cache refills and data-cache refills/write-backs.
- Sits below the F-stage and C-stage caches, whose misses drive `icache_stall`/`dcache_stall` in the core. Each requester receives exclusive ownership of the port for one full-line burst.
- A granted burst always runs to completion.
- Arbitration policy is fixed-priority by default; round-robin when configured.

## Interface
- `LINE_WORDS`, 4, words per cache line / beats per burst; power of two, ≥2.
- `ADDR_W`, 32, address width in bits.
- `clock`  in  1  pipeline clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `ic_req`  in  1  icache refill request; held until `ic_done`.
- `ic_addr`  in  ADDR_W  miss address; sampled at grant.
- `ic_gnt`  out  1  one-cycle pulse: icache burst accepted.
- `ic_rvalid`  out  1  refill beat valid this cycle.
- `ic_rdata`  out  32  refill beat data.
- `ic_done`  out  1  last beat of icache burst this cycle.
- `dc_req`  in  1  dcache request; held until `dc_done`.
- `dc_we`  in  1  1 = write-back burst, 0 = refill; sampled at grant.
- `dc_addr`  in  ADDR_W  line address; sampled at grant.
- `dc_wdata`  in  32  current write-back beat; advanced by the cache on `dc_wready`.
- `dc_gnt`  out  1  one-cycle pulse: dcache burst accepted.
- `dc_rvalid`  out  1  refill beat valid.
- `dc_rdata`  out  32  refill beat data.
- `dc_wready`  out  1  write beat consumed this cycle.
- `dc_done`  out  1  last beat of dcache burst.
- `mem_req`  out  1  burst active, beat requested.
- `mem_we`  out  1  write burst.
- `mem_addr`  out  ADDR_W  current beat address.
- `mem_wdata`  out  32  write data, equal to `dc_wdata` during a write burst, else 0.
- `mem_ready`  in  1  beat completes when `mem_req && mem_ready`; `mem_rdata` is valid in that cycle.
- `mem_rdata`  in  32  read beat data.

## Operation
- **State machine:** IDLE, BURST.
- **IDLE:**
  - If any request is pending, choose an owner, latch the aligned base address and `we`, clear the beat counter, pulse the owner's `gnt` on the next cycle, and go to BURST.
  - ic bursts are always reads.
- **Alignment:** base = `addr` with its low log2(LINE_WORDS*4) bits cleared.
- **BURST:**
  - `mem_req` = 1; `mem_addr` = base + 4*count.
  - Each completed beat increments the counter. On a read, the beat asserts the owner's `rvalid` with `rdata` = `mem_rdata`. On a write, it asserts `dc_wready`.
  - The beat where count == LINE_WORDS-1 also asserts the owner's `done`; the next state is IDLE and the counter returns to 0.
- **Arbitration (default, fixed priority):** dc beats ic on simultaneous requests.
- **Single requester:** a lone requester is always granted.
- **Request ownership:**
  - Deasserting `req` mid-burst does not abort the burst.
  - The non-owner's `req` is ignored until IDLE.
- **Non-owner outputs:** all `rvalid`, `wready`, `done` and `rdata` outputs of the non-owner are 0. `rdata` is 0 whenever `rvalid` is 0.
- **Reset values:** all outputs 0; state IDLE; counter 0; last-owner = DC.
- **Reset mid-burst:** the burst is abandoned immediately and `mem_req` drops asynchronously. Requesters must re-request.

## Timing
- **Grant latency:** `req` sampled high in IDLE at edge N → BURST from N, so `gnt` and `mem_req` are high in cycle N+1.
- **Zero-latency paths:** `rvalid`, `rdata`, `wready` and `done` are combinational from `mem_ready`/`mem_rdata` in the beat cycle.
- **Turnaround:** at least one IDLE cycle between bursts.
  - Back-to-back bursts: `done` in cycle M, next `mem_req` in cycle M+2.
- **Burst length:** minimum LINE_WORDS cycles when `mem_ready` is held high. `mem_ready` low stalls with all `mem_*` outputs held stable.
- **mem_we:** constant for the whole burst.

## Configuration
- **`MEM_ARB_ROUND_ROBIN_EN` defined:** on simultaneous requests, grant the requester that was not the last owner, then update last-owner at each grant.
  - After reset (last-owner = DC), the first tie goes to IC.
- **Not defined:** fixed dc-priority. The last-owner register is absent.

## Test plan
- **Lone ic read:** `ic_req`=1, `ic_addr`=0x0000_1234, `mem_ready`=1 with `mem_rdata` = 0xA0..0xA3 → `mem_addr` 0x1230, 0x1234, 0x1238, 0x123C; four `ic_rvalid` beats carrying 0xA0–0xA3; `ic_done` with the 4th beat; `ic_gnt` pulses once.
- **dc write-back with stall:** `dc_we`=1, `dc_addr`=0x80, `mem_ready` toggling 1,0,1,1,0,1 → exactly four `dc_wready` pulses; `mem_wdata` tracks `dc_wdata`; `mem_we`=1 throughout; `mem_addr` held during the 0-cycles.
- **Simultaneous requests, default build:** → dc served first; ic granted and its `mem_req` high two cycles after `dc_done`.
- **Simultaneous requests with `MEM_ARB_ROUND_ROBIN_EN`, both held through three bursts:** → grant order IC, DC, IC.
- **Reset asserted after beat 2 of an ic burst:** → `mem_req` and all outputs 0 immediately. After release with `ic_req` held, the burst restarts at beat 0 of the aligned base.
- **Owner drops `req` mid-burst, other requester pending:** → current burst still completes all four beats; no non-owner `rvalid`/`done`/`wready` observed; other requester granted next.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one backing-memory port between icache refills and dcache refills/write-backs.
// Default is fixed dc priority; define MEM_ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests.
module mem_port_arbiter #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              ic_req_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    output logic              ic_gnt_o,
    output logic              ic_rvalid_o,
    output logic [31:0]       ic_rdata_o,
    output logic              ic_done_o,
    input  logic              dc_req_i,
    input  logic              dc_we_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic [31:0]       dc_wdata_i,
    output logic              dc_gnt_o,
    output logic              dc_rvalid_o,
    output logic [31:0]       dc_rdata_o,
    output logic              dc_wready_o,
    output logic              dc_done_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic [31:0]       mem_rdata_i
);

    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam int OFF_W = $clog2(LINE_WORDS * 4);

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;   // 1 = dcache owns the port
    logic              we_q, we_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              gnt_q, gnt_d;
    logic              pick_dc;
    logic              beat;
    logic              last_beat;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              last_dc_q, last_dc_d;
    assign pick_dc = dc_req_i & (~ic_req_i | ~last_dc_q);
`else
    assign pick_dc = dc_req_i;
`endif

    assign beat      = (state_q == BURST) & mem_ready_i;
    assign last_beat = (cnt_q == CNT_W'(LINE_WORDS - 1));

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            base_q    <= '0;
            cnt_q     <= '0;
            gnt_q     <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_dc_q <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            base_q    <= base_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_dc_q <= last_dc_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        base_d    = base_q;
        cnt_d     = cnt_q;
        gnt_d     = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_dc_d = last_dc_q;
`endif
        case (state_q)
            IDLE: begin
                if (ic_req_i | dc_req_i) begin
                    state_d = BURST;
                    owner_d = pick_dc;
                    we_d    = pick_dc & dc_we_i;
                    base_d  = pick_dc ? {dc_addr_i[ADDR_W-1:OFF_W], OFF_W'(0)}
                                      : {ic_addr_i[ADDR_W-1:OFF_W], OFF_W'(0)};
                    cnt_d   = '0;
                    gnt_d   = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_dc_d = pick_dc;
`endif
                end
            end
            BURST: begin
                if (mem_ready_i) begin
                    if (last_beat) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat-side outputs are combinational from mem_ready/mem_rdata; everything is 0 outside BURST.
    always_comb begin
        ic_gnt_o    = 1'b0;
        ic_rvalid_o = 1'b0;
        ic_rdata_o  = '0;
        ic_done_o   = 1'b0;
        dc_gnt_o    = 1'b0;
        dc_rvalid_o = 1'b0;
        dc_rdata_o  = '0;
        dc_wready_o = 1'b0;
        dc_done_o   = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (state_q == BURST) begin
            mem_req_o   = 1'b1;
            mem_we_o    = we_q;
            mem_addr_o  = base_q + (ADDR_W'(cnt_q) << 2);
            mem_wdata_o = we_q ? dc_wdata_i : 32'h0;
            if (owner_q) begin
                dc_gnt_o    = gnt_q;
                dc_rvalid_o = beat & ~we_q;
                dc_rdata_o  = (beat & ~we_q) ? mem_rdata_i : 32'h0;
                dc_wready_o = beat & we_q;
                dc_done_o   = beat & last_beat;
            end else begin
                ic_gnt_o    = gnt_q;
                ic_rvalid_o = beat;
                ic_rdata_o  = beat ? mem_rdata_i : 32'h0;
                ic_done_o   = beat & last_beat;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model, per-cycle compare, directed and random traffic.
module tb_mem_port_arbiter;

    localparam int LW = 4;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ic_req = 0, dc_req = 0, dc_we = 0, mem_ready = 0;
    logic [31:0] ic_addr = 0, dc_addr = 0, dc_wdata = 0, mem_rdata = 0;
    logic        ic_gnt, ic_rvalid, ic_done, dc_gnt, dc_rvalid, dc_wready, dc_done;
    logic        mem_req, mem_we;
    logic [31:0] ic_rdata, dc_rdata, mem_addr, mem_wdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.LINE_WORDS(LW), .ADDR_W(32)) dut (
        .clock_i(clk), .reset_i(reset),
        .ic_req_i(ic_req), .ic_addr_i(ic_addr), .ic_gnt_o(ic_gnt), .ic_rvalid_o(ic_rvalid),
        .ic_rdata_o(ic_rdata), .ic_done_o(ic_done),
        .dc_req_i(dc_req), .dc_we_i(dc_we), .dc_addr_i(dc_addr), .dc_wdata_i(dc_wdata),
        .dc_gnt_o(dc_gnt), .dc_rvalid_o(dc_rvalid), .dc_rdata_o(dc_rdata),
        .dc_wready_o(dc_wready), .dc_done_o(dc_done),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata)
    );

    int checks = 0;
    int failures = 0;

    // Transaction-level model of the port: who owns it, which line, which beat.
    bit          m_busy = 0, m_owner_dc = 0, m_we = 0, m_gnt_ic = 0, m_gnt_dc = 0, m_last_dc = 1;
    logic [31:0] m_base = 0;
    int          m_beat = 0;
    int          grant_log[$];

    // Requester behaviour: 0 idle, 1 waiting for grant, 2 owning a burst.
    int  ic_st = 0, dc_st = 0;
    bit  rand_en = 0, drop_en = 0, hold_both = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit bt, lst;
        bt  = m_busy && mem_ready;
        lst = bt && (m_beat == LW - 1);
        chk("mem_req",   32'(mem_req), 32'(m_busy));
        chk("mem_we",    32'(mem_we), 32'(m_busy && m_we));
        chk("mem_addr",  mem_addr, m_busy ? m_base + 32'(4 * m_beat) : 32'h0);
        chk("mem_wdata", mem_wdata, (m_busy && m_we) ? dc_wdata : 32'h0);
        chk("ic_gnt",    32'(ic_gnt), 32'(m_gnt_ic));
        chk("dc_gnt",    32'(dc_gnt), 32'(m_gnt_dc));
        chk("ic_rvalid", 32'(ic_rvalid), 32'(bt && !m_owner_dc));
        chk("ic_rdata",  ic_rdata, (bt && !m_owner_dc) ? mem_rdata : 32'h0);
        chk("ic_done",   32'(ic_done), 32'(lst && !m_owner_dc));
        chk("dc_rvalid", 32'(dc_rvalid), 32'(bt && m_owner_dc && !m_we));
        chk("dc_rdata",  dc_rdata, (bt && m_owner_dc && !m_we) ? mem_rdata : 32'h0);
        chk("dc_wready", 32'(dc_wready), 32'(bt && m_owner_dc && m_we));
        chk("dc_done",   32'(dc_done), 32'(lst && m_owner_dc));
    end

    task automatic raise_ic(input logic [31:0] a);
        ic_req = 1; ic_addr = a; ic_st = 1;
    endtask

    task automatic raise_dc(input logic we, input logic [31:0] a);
        dc_req = 1; dc_we = we; dc_addr = a; dc_st = 1; dc_wdata = $urandom;
    endtask

    task automatic assert_reset();
        reset = 1;
        m_busy = 0; m_gnt_ic = 0; m_gnt_dc = 0; m_beat = 0; m_last_dc = 1;
    endtask

    // One clock: advance the model with the inputs seen at the edge, then drive new inputs.
    task automatic cycle();
        bit pick_dc;
        @(posedge clk);
        #1;
        if (!reset) begin
            m_gnt_ic = 0;
            m_gnt_dc = 0;
            if (!m_busy) begin
                if (ic_req || dc_req) begin
                    if (ic_req && dc_req) pick_dc = RR ? !m_last_dc : 1'b1;
                    else                  pick_dc = dc_req;
                    m_owner_dc = pick_dc;
                    m_we       = pick_dc ? dc_we : 1'b0;
                    m_base     = (pick_dc ? dc_addr : ic_addr) & ~32'(LW * 4 - 1);
                    m_beat     = 0;
                    m_busy     = 1;
                    m_last_dc  = pick_dc;
                    if (pick_dc) begin m_gnt_dc = 1; dc_st = 2; end
                    else         begin m_gnt_ic = 1; ic_st = 2; end
                    grant_log.push_back(int'(pick_dc));
                end
            end else if (mem_ready) begin
                if (m_owner_dc && m_we) dc_wdata = $urandom;
                if (m_beat == LW - 1) begin
                    m_busy = 0;
                    m_beat = 0;
                    if (m_owner_dc) begin
                        dc_st = 0; dc_req = 0;
                        if (hold_both) raise_dc(dc_we, dc_addr);
                    end else begin
                        ic_st = 0; ic_req = 0;
                        if (hold_both) raise_ic(ic_addr);
                    end
                end else begin
                    m_beat++;
                end
            end
        end
        if (drop_en && ic_st == 2 && $urandom_range(0, 2) == 0) ic_req = 0;
        if (drop_en && dc_st == 2 && $urandom_range(0, 2) == 0) dc_req = 0;
        if (rand_en) begin
            if (ic_st == 0 && $urandom_range(0, 3) == 0) raise_ic($urandom);
            if (dc_st == 0 && $urandom_range(0, 3) == 0) raise_dc(1'($urandom), $urandom);
            mem_ready = ($urandom_range(0, 3) != 0);
        end
        mem_rdata = $urandom;
    endtask

    task automatic drain();
        for (int i = 0; i < 80; i++) begin
            if (!m_busy && ic_st == 0 && dc_st == 0) break;
            mem_ready = 1;
            cycle();
        end
        chk("drain_idle", 32'(!m_busy && ic_st == 0 && dc_st == 0), 32'h1);
    endtask

    initial begin
        bit pat[6];
        int nb, wr_cnt, dcv, icv, t_done, t_g, seen_done, seen_g;
        logic first_dc;
        pat = '{1, 0, 1, 1, 0, 1};

        repeat (3) @(posedge clk);
        #2;
        chk("reset_mem_req", 32'(mem_req), 32'h0);
        chk("reset_mem_addr", mem_addr, 32'h0);
        chk("reset_gnt", 32'({ic_gnt, dc_gnt}), 32'h0);
        @(posedge clk); #1 reset = 0;

        // Lone ic read
        mem_ready = 1;
        raise_ic(32'h0000_1234);
        for (int b = 0; b < LW; b++) begin
            cycle();
            mem_rdata = 32'hA0 + 32'(b);
            #1;
            chk("ic_read_addr", mem_addr, 32'h1230 + 32'(4 * b));
            chk("ic_read_data", ic_rdata, 32'hA0 + 32'(b));
            chk("ic_read_valid", 32'(ic_rvalid), 32'h1);
            chk("ic_read_done", 32'(ic_done), 32'(b == LW - 1));
            chk("ic_read_gnt", 32'(ic_gnt), 32'(b == 0));
        end
        drain();

        // dc write-back with stalls
        raise_dc(1, 32'h0000_0080);
        nb = 0; wr_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            mem_ready = pat[i];
            #1;
            wr_cnt += int'(dc_wready);
            chk("wb_addr", mem_addr, 32'h80 + 32'(4 * nb));
            chk("wb_we", 32'(mem_we), 32'h1);
            chk("wb_wdata", mem_wdata, dc_wdata);
            chk("wb_done", 32'(dc_done), 32'(i == 5));
            nb += int'(pat[i]);
        end
        chk("wb_wready_count", 32'(wr_cnt), 32'd4);
        mem_ready = 1;
        drain();

        // Simultaneous requests: first winner by policy, second grant two cycles after done
        raise_ic(32'h0000_2000);
        raise_dc(0, 32'h0000_3000);
        cycle();
        #1;
        first_dc = dc_gnt;
        chk("simul_first_dc", 32'(first_dc), 32'(!RR));
        seen_done = 0; seen_g = 0; t_done = -100; t_g = -50;
        for (int i = 1; i < 30; i++) begin
            cycle();
            #1;
            if (!seen_done && (ic_done || dc_done)) begin seen_done = 1; t_done = i; end
            if (!seen_g && (ic_gnt || dc_gnt)) begin
                seen_g = 1; t_g = i;
                chk("simul_second_owner", 32'(dc_gnt), 32'(!first_dc));
                chk("simul_second_req", 32'(mem_req), 32'h1);
            end
        end
        chk("simul_turnaround", 32'(t_g - t_done), 32'd2);
        drain();

        // Both held through three bursts
        grant_log.delete();
        hold_both = 1;
        raise_ic(32'h0000_4000);
        raise_dc(0, 32'h0000_5000);
        for (int i = 0; i < 60 && grant_log.size() < 3; i++) cycle();
        hold_both = 0;
        chk("order_len", 32'(grant_log.size()), 32'd3);
        if (grant_log.size() >= 3) begin
            chk("order0", 32'(grant_log[0]), RR ? 32'd0 : 32'd1);
            chk("order1", 32'(grant_log[1]), 32'd1);
            chk("order2", 32'(grant_log[2]), RR ? 32'd0 : 32'd1);
        end
        drain();

        // Reset during an ic burst, then restart from the aligned base
        raise_ic(32'h0000_1234);
        cycle();
        cycle();
        cycle();
        #1;
        assert_reset();
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_outputs", 32'({ic_rvalid, ic_done, ic_gnt, mem_we}), 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        ic_st = 1;
        cycle();
        reset = 0;
        cycle();
        #1;
        chk("rst_restart_gnt", 32'(ic_gnt), 32'h1);
        chk("rst_restart_addr", mem_addr, 32'h1230);
        drain();

        // Owner drops req mid-burst with the other side pending
        raise_dc(0, 32'h0000_0400);
        dcv = 0; icv = 0;
        cycle();
        dc_req = 0;
        raise_ic(32'h0000_0500);
        #1;
        dcv += int'(dc_rvalid); icv += int'(ic_rvalid || ic_done);
        for (int i = 1; i < LW; i++) begin
            cycle();
            #1;
            dcv += int'(dc_rvalid); icv += int'(ic_rvalid || ic_done);
        end
        chk("drop_dc_beats", 32'(dcv), 32'(LW));
        chk("drop_no_ic", 32'(icv), 32'h0);
        cycle();
        cycle();
        #1;
        chk("drop_ic_next", 32'(ic_gnt), 32'h1);
        drain();

        // Randomized traffic
        rand_en = 1;
        drop_en = 1;
        repeat (2000) cycle();
        rand_en = 0;
        drop_en = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
